// File: rtl/ifetch_mem_responder.sv
// rtl/ifetch_mem_responder.sv - instruction fetch responder on a byte-wide RAM port
//
// Reads one little-endian instruction per accepted request. The address may be
// halfword-aligned. Byte0[1:0]==2'b11 selects a 32-bit instruction; anything else
// is a 16-bit compressed instruction, returned zero-extended.
//
// Optional feature macro: ICACHE_EN (direct-mapped instruction cache).
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   clear             flush: abort the in-flight fetch, no data_ready for it
//   asking, addr      fetch request and its address (addr[31:ADDR_W] ignored)
//   mem_busy          RAM port owned by another master; only blocks a new fetch start
//   mem_din           RAM read byte, valid two edges after mem_a was registered
//   mem_a, mem_rd_en  RAM byte address and read strobe
//   data, data_ready  fetched instruction (held) and its one-cycle valid pulse
module ifetch_mem_responder #(
  parameter int ADDR_W       = 17,
  parameter int ICACHE_LINES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              asking,
  input  logic [31:0]       addr,
  input  logic              mem_busy,
  input  logic [7:0]        mem_din,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_rd_en,
  output logic [31:0]       data,
  output logic              data_ready
);

  typedef enum logic {IDLE, FETCH} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic              mem_rd_en_q, mem_rd_en_d;
  logic [2:0]        iss_cnt_q, iss_cnt_d;
  logic [2:0]        rcv_cnt_q, rcv_cnt_d;
  logic [2:0]        cyc_q, cyc_d;
  logic [2:0]        len_q, len_d;
  logic [23:0]       byte_buf_q, byte_buf_d;
  logic [31:0]       data_q, data_d;
  logic              data_ready_q, data_ready_d;

  logic [2:0]        len_eff;
  logic [31:0]       word;
  logic              cache_hit;
  logic [31:0]       cache_rdata;
  logic              fill_we;
  logic [31:0]       fill_data;

  wire unused_addr_hi = ^addr[31:ADDR_W];

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    mem_a_d      = mem_a_q;
    mem_rd_en_d  = mem_rd_en_q;
    iss_cnt_d    = iss_cnt_q;
    rcv_cnt_d    = rcv_cnt_q;
    cyc_d        = cyc_q;
    len_d        = len_q;
    byte_buf_d   = byte_buf_q;
    data_d       = data_q;
    data_ready_d = 1'b0;
    fill_we      = 1'b0;
    fill_data    = 32'h0;

    // Length becomes known the edge byte0 arrives; that same edge must already
    // see the short length so the base+2 issue is suppressed.
    len_eff = len_q;
    if (state_q == FETCH && cyc_q == 3'd2 && mem_din[1:0] != 2'b11) begin
      len_eff = 3'd2;
    end

    if (len_eff == 3'd2) begin
      word = {16'h0, mem_din, byte_buf_q[7:0]};
    end else begin
      word = {mem_din, byte_buf_q[23:0]};
    end

    case (state_q)
      IDLE: begin
        mem_rd_en_d = 1'b0;
        if (asking && cache_hit) begin
          data_d       = cache_rdata;
          data_ready_d = 1'b1;
        end else if (asking && !mem_busy) begin
          state_d     = FETCH;
          base_d      = addr[ADDR_W-1:0];
          mem_a_d     = addr[ADDR_W-1:0];
          mem_rd_en_d = 1'b1;
          iss_cnt_d   = 3'd1;
          rcv_cnt_d   = 3'd0;
          cyc_d       = 3'd1;
          len_d       = 3'd4;
        end
      end

      FETCH: begin
        cyc_d = cyc_q + 3'd1;
        len_d = len_eff;

        // Strobe stays high exactly while a needed address is being presented.
        if (iss_cnt_q < len_eff) begin
          mem_a_d     = base_q + ADDR_W'(iss_cnt_q);
          iss_cnt_d   = iss_cnt_q + 3'd1;
          mem_rd_en_d = 1'b1;
        end else begin
          mem_rd_en_d = 1'b0;
        end

        if (cyc_q >= 3'd2) begin
          rcv_cnt_d = rcv_cnt_q + 3'd1;
          case (rcv_cnt_q)
            3'd0:    byte_buf_d[7:0]   = mem_din;
            3'd1:    byte_buf_d[15:8]  = mem_din;
            3'd2:    byte_buf_d[23:16] = mem_din;
            default: byte_buf_d        = byte_buf_q;
          endcase
          if (rcv_cnt_q == len_eff - 3'd1) begin
            state_d      = IDLE;
            mem_rd_en_d  = 1'b0;
            data_d       = word;
            data_ready_d = 1'b1;
            fill_we      = 1'b1;
            fill_data    = word;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    if (clear) begin
      state_d      = IDLE;
      mem_a_d      = mem_a_q;
      mem_rd_en_d  = 1'b0;
      data_d       = data_q;
      data_ready_d = 1'b0;
      fill_we      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      base_q       <= '0;
      mem_a_q      <= '0;
      mem_rd_en_q  <= 1'b0;
      iss_cnt_q    <= 3'd0;
      rcv_cnt_q    <= 3'd0;
      cyc_q        <= 3'd0;
      len_q        <= 3'd4;
      byte_buf_q   <= 24'h0;
      data_q       <= 32'h0;
      data_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      mem_a_q      <= mem_a_d;
      mem_rd_en_q  <= mem_rd_en_d;
      iss_cnt_q    <= iss_cnt_d;
      rcv_cnt_q    <= rcv_cnt_d;
      cyc_q        <= cyc_d;
      len_q        <= len_d;
      byte_buf_q   <= byte_buf_d;
      data_q       <= data_d;
      data_ready_q <= data_ready_d;
    end
  end

`ifdef ICACHE_EN
  localparam int IDX_W = $clog2(ICACHE_LINES);
  localparam int TAG_W = ADDR_W - IDX_W - 1;

  logic              cache_valid_q [ICACHE_LINES];
  logic [TAG_W-1:0]  cache_tag_q   [ICACHE_LINES];
  logic [31:0]       cache_data_q  [ICACHE_LINES];
  logic [IDX_W-1:0]  req_idx, fill_idx;
  logic [TAG_W-1:0]  req_tag, fill_tag;

  // Lookup uses the live request address; fill uses the latched base of the
  // fetch that is completing.
  assign req_idx     = addr[IDX_W:1];
  assign req_tag     = addr[ADDR_W-1:IDX_W+1];
  assign fill_idx    = base_q[IDX_W:1];
  assign fill_tag    = base_q[ADDR_W-1:IDX_W+1];
  assign cache_hit   = (state_q == IDLE) && cache_valid_q[req_idx] &&
                       (cache_tag_q[req_idx] == req_tag);
  assign cache_rdata = cache_data_q[req_idx];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ICACHE_LINES; i++) begin
        cache_valid_q[i] <= 1'b0;
      end
    end else if (fill_we) begin
      cache_valid_q[fill_idx] <= 1'b1;
      cache_tag_q[fill_idx]   <= fill_tag;
      cache_data_q[fill_idx]  <= fill_data;
    end
  end

  wire unused_addr_lsb = addr[0];
`else
  localparam int unused_lines = ICACHE_LINES;

  assign cache_hit   = 1'b0;
  assign cache_rdata = 32'h0;

  wire unused_fill = fill_we ^ (^fill_data);
`endif

  assign mem_a      = mem_a_q;
  assign mem_rd_en  = mem_rd_en_q;
  assign data       = data_q;
  assign data_ready = data_ready_q;

endmodule

// File: tb/tb_ifetch_mem_responder.sv
// tb/tb_ifetch_mem_responder.sv - scoreboard bench for ifetch_mem_responder
module tb_ifetch_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        asking = 1'b0;
  logic [31:0] addr = 32'h0;
  logic        mem_busy = 1'b0;
  logic [7:0]  mem_din = 8'h0;
  logic [16:0] mem_a;
  logic        mem_rd_en;
  logic [31:0] data;
  logic        data_ready;

  ifetch_mem_responder #(.ADDR_W(17), .ICACHE_LINES(16)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .asking(asking), .addr(addr),
    .mem_busy(mem_busy), .mem_din(mem_din), .mem_a(mem_a), .mem_rd_en(mem_rd_en),
    .data(data), .data_ready(data_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          rdy;
  } exp_t;

  logic [7:0]  ram [0:131071];
  exp_t        exp_q[$];
  logic [16:0] iss_log[$];
  logic [31:0] last_data = 32'h0;
  int          cnt = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  bit          mdl_v [16];
  logic [15:0] mdl_a [16];
  logic [31:0] mdl_d [16];

  always @(posedge clk) cnt <= cnt + 1;
  always @(posedge clk) mem_din <= ram[mem_a];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cnt);
    end
  endtask

  always @(negedge clk) begin
    if (mem_rd_en) iss_log.push_back(mem_a);
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (data_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ready", {31'h0, data_ready}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("data", data, e.data);
          check("ready_cycle", cnt, e.rdy);
          check("rd_en_at_ready", {31'h0, mem_rd_en}, 32'h0);
          last_data = e.data;
        end
      end else begin
        check("data_hold", data, last_data);
      end
    end
  end

  function automatic logic [31:0] ref_word(input logic [16:0] a);
    logic [7:0] b [4];
    for (int k = 0; k < 4; k++) b[k] = ram[17'(a + 17'(k))];
    if (b[0][1:0] == 2'b11) return {b[3], b[2], b[1], b[0]};
    return {16'h0, b[1], b[0]};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; asking = 1'b0; clear = 1'b0; mem_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_a", {15'h0, mem_a}, 32'h0);
    check("rst_rd_en", {31'h0, mem_rd_en}, 32'h0);
    check("rst_data", data, 32'h0);
    check("rst_ready", {31'h0, data_ready}, 32'h0);
    last_data = 32'h0;
    for (int i = 0; i < 16; i++) mdl_v[i] = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic do_fetch(input logic [16:0] a, input bit use_k, input logic [31:0] k);
    logic [31:0] w;
    int          len;
    bit          hit;
    int          nb;
    exp_t        e;
    hit = 1'b0;
    w   = ref_word(a);
    len = (ram[a][1:0] == 2'b11) ? 4 : 2;
`ifdef ICACHE_EN
    if (mdl_v[a[4:1]] && mdl_a[a[4:1]] == a[16:1]) begin
      hit = 1'b1;
      w   = mdl_d[a[4:1]];
    end else begin
      mdl_v[a[4:1]] = 1'b1;
      mdl_a[a[4:1]] = a[16:1];
      mdl_d[a[4:1]] = w;
    end
`endif
    if (use_k) w = k;
    iss_log.delete();
    asking = 1'b1;
    addr   = {15'($urandom), a};
    nb     = hit ? 0 : $urandom_range(0, 2);
    repeat (nb) begin
      mem_busy = 1'b1;
      @(posedge clk);
      #1;
    end
    mem_busy = hit ? 1'($urandom) : 1'b0;
    e.data = w;
    e.rdy  = cnt + 1 + (hit ? 0 : (len == 4 ? 5 : 3));
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    asking   = 1'b0;
    mem_busy = 1'($urandom);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      check("resp_timeout", exp_q.size(), 32'h0);
      exp_q.delete();
    end
    @(negedge clk);
    #1;
    mem_busy = 1'b0;
    check("issue_count", iss_log.size(), hit ? 0 : len);
    if (!hit) begin
      for (int j = 0; j < len && j < iss_log.size(); j++) begin
        check("issue_addr", {15'h0, iss_log[j]}, {15'h0, 17'(a + 17'(j))});
      end
    end
  endtask

  task automatic set_case1_ram();
    ram[17'h100] = 8'h93; ram[17'h101] = 8'h00; ram[17'h102] = 8'h10; ram[17'h103] = 8'h00;
    ram[17'h104] = 8'h01; ram[17'h105] = 8'h45;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 131072; i++) ram[i] = 8'($urandom);
    set_case1_ram();
    ram[17'h1FFFE] = 8'h13; ram[17'h1FFFF] = 8'h05; ram[17'h00000] = 8'h00; ram[17'h00001] = 8'h00;

    do_reset();

    // Abort a 32-bit fetch with clear after three addresses went out.
    iss_log.delete();
    asking = 1'b1; addr = 32'h100; mem_busy = 1'b0;
    @(posedge clk); #1; asking = 1'b0;
    @(posedge clk); @(posedge clk); #1; clear = 1'b1;
    @(posedge clk); #1; clear = 1'b0;
    @(negedge clk);
    check("clear_rd_en", {31'h0, mem_rd_en}, 32'h0);
    repeat (10) @(posedge clk);
    #1;
    check("clear_issue_count", iss_log.size(), 32'd3);

    do_fetch(17'h00104, 1'b1, 32'h00004501);
    do_fetch(17'h00100, 1'b1, 32'h00100093);
    do_fetch(17'h00104, 1'b1, 32'h00004501);
    ram[17'h102] = 8'hB7; ram[17'h103] = 8'h02; ram[17'h104] = 8'h00; ram[17'h105] = 8'h00;
    do_fetch(17'h00102, 1'b1, 32'h000002B7);
    do_fetch(17'h1FFFE, 1'b1, 32'h00000513);
    set_case1_ram();

`ifdef ICACHE_EN
    do_fetch(17'h00100, 1'b1, 32'h00100093);
    do_reset();
    do_fetch(17'h00100, 1'b1, 32'h00100093);
`endif

    // clear coinciding with asking drops the request.
    iss_log.delete();
    asking = 1'b1; clear = 1'b1; addr = 32'h104;
    @(posedge clk); #1; asking = 1'b0; clear = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("clear_ask_issue", iss_log.size(), 32'd0);

    for (int n = 0; n < 60; n++) begin
      logic [16:0] a;
      if ($urandom_range(0, 1) == 0) a = {11'h0, 5'($urandom), 1'b0};
      else a = {16'($urandom), 1'b0};
      do_fetch(a, 1'b0, 32'h0);
    end

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
